// File: rtl/pipo_universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate and clear, plus an
// autonomous parallel-to-serial converter with busy/done status.
module pipo_universal_shift_reg #(
    parameter int             WIDTH         = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int             SER_MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SER
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // start outranks mode so a serialisation is never lost to a register op
                if (start) begin
                    q_d     = D;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SER;
                end else begin
                    case (mode)
                        3'b001:  q_d = {sin_l, q_q[WIDTH-1:1]};
                        3'b010:  q_d = {q_q[WIDTH-2:0], sin_r};
                        3'b011:  q_d = D;
                        3'b100:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                        3'b101:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        3'b110:  q_d = '0;
                        default: q_d = q_q;
                    endcase
                end
            end
            SER: begin
                if (SER_MSB_FIRST != 0) begin
                    q_d = {q_q[WIDTH-2:0], sin_r};
                end else begin
                    q_d = {sin_l, q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign sout_r  = q_q[0];
    assign sout_l  = q_q[WIDTH-1];
    assign ser_out = (SER_MSB_FIRST != 0) ? q_q[WIDTH-1] : q_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
